// File: rtl/bblock.sv
// -----------------------------------------------------------------------------
// bblock: five-way modular redundancy cell with a majority voter.
//
// Each cycle the data bit x is captured into five replica registers. Replica i
// is inverted when its fault-inject input g<i> is high. The registered replicas
// feed a combinational 3-of-5 majority voter. Per-replica disagreement flags
// and a registered fault count are reported alongside the voted result.
//
// Ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset (clears replicas and count)
//   x     in   1  data bit to replicate
//   g1-g5 in   1  fault inject per replica (1 = replica inverted)
//   A     out  1  majority of the five replicas
//   mis   out  5  bit i-1 set when replica i disagrees with A
//   fcnt  out  3  number of faulted replicas captured on the last edge (0..5)
//   unc   out  1  set when fcnt >= 3, i.e. the vote is overturned
//
// Every output depends only on registers, so the latency from any input to any
// output is exactly one clock.
// -----------------------------------------------------------------------------
module bblock (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       g1,
    input  logic       g2,
    input  logic       g3,
    input  logic       g4,
    input  logic       g5,
    output logic       A,
    output logic [4:0] mis,
    output logic [2:0] fcnt,
    output logic       unc
);

    // Number of set bits in a 5-bit vector.
    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // 3-of-5 majority.
    function automatic logic majority5(input logic [4:0] v);
        return (popcount5(v) >= 3'd3);
    endfunction

    logic [4:0] g_vec;
    logic [4:0] r_p1;
    logic [2:0] fcnt_p1;

    assign g_vec = {g5, g4, g3, g2, g1};

    // Stage p0 -> p1: capture replicas and fault count.
    // The replicas hold the redundant data themselves, so reset clears them as
    // well as the count; this gives the defined all-zero output after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1    <= 5'b00000;
            fcnt_p1 <= 3'd0;
        end else begin
            r_p1    <= {5{x}} ^ g_vec;
            fcnt_p1 <= popcount5(g_vec);
        end
    end

    // Stage p1 outputs: vote and diagnostics, purely from registered state.
    always_comb begin
        A    = majority5(r_p1);
        mis  = r_p1 ^ {5{A}};
        fcnt = fcnt_p1;
        unc  = (fcnt_p1 >= 3'd3);
    end

endmodule

// File: tb/tb_bblock.sv
// -----------------------------------------------------------------------------
// tb_bblock: directed self-checking bench for bblock.
// Inputs are driven with blocking assignments away from the clock edge and the
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bblock;

    logic       clk;
    logic       rst;
    logic       x;
    logic       g1, g2, g3, g4, g5;
    logic       A;
    logic [4:0] mis;
    logic [2:0] fcnt;
    logic       unc;

    int total;
    int bad;

    bblock dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .g1   (g1),
        .g2   (g2),
        .g3   (g3),
        .g4   (g4),
        .g5   (g5),
        .A    (A),
        .mis  (mis),
        .fcnt (fcnt),
        .unc  (unc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive data and fault injects; gv is {g5,g4,g3,g2,g1}.
    task automatic drive(input logic xv, input logic [4:0] gv);
        x  = xv;
        g1 = gv[0];
        g2 = gv[1];
        g3 = gv[2];
        g4 = gv[3];
        g5 = gv[4];
    endtask

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'b11111);
        tick();
        tick();
        total++; if (A !== 1'b0)      begin bad++; $display("FAIL reset_A got=%b want=0", A); end
        total++; if (mis !== 5'b00000) begin bad++; $display("FAIL reset_mis got=%b want=00000", mis); end
        total++; if (fcnt !== 3'd0)   begin bad++; $display("FAIL reset_fcnt got=%0d want=0", fcnt); end
        total++; if (unc !== 1'b0)    begin bad++; $display("FAIL reset_unc got=%b want=0", unc); end
        rst = 1'b0;
    endtask

    task automatic test_no_fault_toggle();
        drive(1'b1, 5'b00000);
        #1;
        // Outputs must not react before the edge.
        total++; if (A !== 1'b0) begin bad++; $display("FAIL comb_path_A got=%b want=0", A); end
        tick();
        total++; if (A !== 1'b1)      begin bad++; $display("FAIL toggle1_A got=%b want=1", A); end
        total++; if (mis !== 5'b00000) begin bad++; $display("FAIL toggle1_mis got=%b want=00000", mis); end
        total++; if (fcnt !== 3'd0)   begin bad++; $display("FAIL toggle1_fcnt got=%0d want=0", fcnt); end
        drive(1'b0, 5'b00000);
        tick();
        total++; if (A !== 1'b0)      begin bad++; $display("FAIL toggle0_A got=%b want=0", A); end
        total++; if (mis !== 5'b00000) begin bad++; $display("FAIL toggle0_mis got=%b want=00000", mis); end
        total++; if (fcnt !== 3'd0)   begin bad++; $display("FAIL toggle0_fcnt got=%0d want=0", fcnt); end
    endtask

    task automatic test_single_fault();
        drive(1'b1, 5'b00100);
        tick();
        total++; if (A !== 1'b1)      begin bad++; $display("FAIL sf1_A got=%b want=1", A); end
        total++; if (mis !== 5'b00100) begin bad++; $display("FAIL sf1_mis got=%b want=00100", mis); end
        total++; if (fcnt !== 3'd1)   begin bad++; $display("FAIL sf1_fcnt got=%0d want=1", fcnt); end
        total++; if (unc !== 1'b0)    begin bad++; $display("FAIL sf1_unc got=%b want=0", unc); end
        drive(1'b0, 5'b00100);
        tick();
        total++; if (A !== 1'b0)      begin bad++; $display("FAIL sf0_A got=%b want=0", A); end
        total++; if (mis !== 5'b00100) begin bad++; $display("FAIL sf0_mis got=%b want=00100", mis); end
        total++; if (fcnt !== 3'd1)   begin bad++; $display("FAIL sf0_fcnt got=%0d want=1", fcnt); end
    endtask

    task automatic test_two_faults();
        drive(1'b0, 5'b11000);
        tick();
        total++; if (A !== 1'b0)      begin bad++; $display("FAIL tf_A got=%b want=0", A); end
        total++; if (mis !== 5'b11000) begin bad++; $display("FAIL tf_mis got=%b want=11000", mis); end
        total++; if (fcnt !== 3'd2)   begin bad++; $display("FAIL tf_fcnt got=%0d want=2", fcnt); end
        total++; if (unc !== 1'b0)    begin bad++; $display("FAIL tf_unc got=%b want=0", unc); end
    endtask

    task automatic test_majority_loss();
        drive(1'b1, 5'b00111);
        tick();
        total++; if (A !== 1'b0)      begin bad++; $display("FAIL ml_A got=%b want=0", A); end
        total++; if (mis !== 5'b11000) begin bad++; $display("FAIL ml_mis got=%b want=11000", mis); end
        total++; if (fcnt !== 3'd3)   begin bad++; $display("FAIL ml_fcnt got=%0d want=3", fcnt); end
        total++; if (unc !== 1'b1)    begin bad++; $display("FAIL ml_unc got=%b want=1", unc); end
        // All five faulted with x=0: every replica reads 1.
        drive(1'b0, 5'b11111);
        tick();
        total++; if (A !== 1'b1)      begin bad++; $display("FAIL all_A got=%b want=1", A); end
        total++; if (mis !== 5'b00000) begin bad++; $display("FAIL all_mis got=%b want=00000", mis); end
        total++; if (fcnt !== 3'd5)   begin bad++; $display("FAIL all_fcnt got=%0d want=5", fcnt); end
        total++; if (unc !== 1'b1)    begin bad++; $display("FAIL all_unc got=%b want=1", unc); end
    endtask

    // Each row: x, {g5..g1}, expected A, mis, fcnt, unc (hand-computed).
    task automatic test_back_to_back();
        logic       xs   [6];
        logic [4:0] gs   [6];
        logic       ea   [6];
        logic [4:0] em   [6];
        logic [2:0] ef   [6];
        logic       eu   [6];
        xs[0] = 1'b1; gs[0] = 5'b00000; ea[0] = 1'b1; em[0] = 5'b00000; ef[0] = 3'd0; eu[0] = 1'b0;
        xs[1] = 1'b0; gs[1] = 5'b00001; ea[1] = 1'b0; em[1] = 5'b00001; ef[1] = 3'd1; eu[1] = 1'b0;
        xs[2] = 1'b1; gs[2] = 5'b10010; ea[2] = 1'b1; em[2] = 5'b10010; ef[2] = 3'd2; eu[2] = 1'b0;
        xs[3] = 1'b0; gs[3] = 5'b01111; ea[3] = 1'b1; em[3] = 5'b10000; ef[3] = 3'd4; eu[3] = 1'b1;
        xs[4] = 1'b1; gs[4] = 5'b11111; ea[4] = 1'b0; em[4] = 5'b00000; ef[4] = 3'd5; eu[4] = 1'b1;
        xs[5] = 1'b0; gs[5] = 5'b00000; ea[5] = 1'b0; em[5] = 5'b00000; ef[5] = 3'd0; eu[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(xs[i], gs[i]);
            tick();
            total++; if (A !== ea[i])    begin bad++; $display("FAIL b2b%0d_A got=%b want=%b", i, A, ea[i]); end
            total++; if (mis !== em[i])  begin bad++; $display("FAIL b2b%0d_mis got=%b want=%b", i, mis, em[i]); end
            total++; if (fcnt !== ef[i]) begin bad++; $display("FAIL b2b%0d_fcnt got=%0d want=%0d", i, fcnt, ef[i]); end
            total++; if (unc !== eu[i])  begin bad++; $display("FAIL b2b%0d_unc got=%b want=%b", i, unc, eu[i]); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'b00011);
        tick();
        total++; if (fcnt !== 3'd2) begin bad++; $display("FAIL rm_pre_fcnt got=%0d want=2", fcnt); end
        total++; if (A !== 1'b1)    begin bad++; $display("FAIL rm_pre_A got=%b want=1", A); end
        // Reset wins over active data and faults on the same edge.
        rst = 1'b1;
        drive(1'b1, 5'b11111);
        tick();
        total++; if (A !== 1'b0)      begin bad++; $display("FAIL rm_A got=%b want=0", A); end
        total++; if (mis !== 5'b00000) begin bad++; $display("FAIL rm_mis got=%b want=00000", mis); end
        total++; if (fcnt !== 3'd0)   begin bad++; $display("FAIL rm_fcnt got=%0d want=0", fcnt); end
        total++; if (unc !== 1'b0)    begin bad++; $display("FAIL rm_unc got=%b want=0", unc); end
        rst = 1'b0;
        drive(1'b1, 5'b00100);
        tick();
        total++; if (A !== 1'b1)      begin bad++; $display("FAIL rm_post_A got=%b want=1", A); end
        total++; if (mis !== 5'b00100) begin bad++; $display("FAIL rm_post_mis got=%b want=00100", mis); end
        total++; if (fcnt !== 3'd1)   begin bad++; $display("FAIL rm_post_fcnt got=%0d want=1", fcnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, 5'b00000);
        #1;
        test_reset();
        test_no_fault_toggle();
        test_single_fault();
        test_two_faults();
        test_majority_loss();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
